shader_zsched: RTL
==================

SHADER_ZSCHED -- requirements
Module: shader_zsched

Interface
REQ-001 Parameter ZGROUPS, default 1; number of 5-layer Z groups; ZLAYERS = 5*ZGROUPS.
REQ-002 Parameter SHADERS_POW2, default 3; SHADERS = 2**SHADERS_POW2 affine shader lanes.
REQ-003 Parameter TIMEOUT, default 255; maximum WAIT cycles per layer, range 1..65535.
REQ-004 aclk  in  1  sole clock; all state changes on rising edge.
REQ-005 aresetn  in  1  asynchronous, active-low reset.
REQ-006 strobe  in  1  frame start request; accepted only while ready=1.
REQ-007 layer_en  in  ZLAYERS  per-layer enable, sampled on the accepted strobe only.
REQ-008 abort  in  1  cancels the frame in progress.
REQ-009 sh_done  in  SHADERS  per-lane completion pulse from the shader bank.
REQ-010 ready  out  1  high only in IDLE.
REQ-011 sh_strobe  out  SHADERS  broadcast start pulse to all lanes.
REQ-012 layer_sel  out  $clog2(ZLAYERS)  index of the layer being shaded.
REQ-013 layer_valid  out  1  high in ISSUE and WAIT.
REQ-014 frame_done  out  1  one-cycle pulse on normal frame completion.
REQ-015 timeout_err  out  1  sticky layer-timeout flag.

Function
REQ-016 FSM states shall be IDLE, SCAN, ISSUE, WAIT, DONE, with one state per cycle except WAIT.
REQ-017 IDLE + strobe: latch layer_en into pending, clear timeout_err; next state SCAN if pending!=0, otherwise DONE.
REQ-018 strobe while ready=0 shall be ignored and not queued.
REQ-019 SCAN: layer_sel <= index of lowest set pending bit; clear that bit and done_acc; next ISSUE.
REQ-020 ISSUE: sh_strobe = all ones for exactly this cycle; zero in every other state; next WAIT.
REQ-021 done_acc (SHADERS bits) shall accumulate sh_done by sticky OR during ISSUE and WAIT.
REQ-022 WAIT exits when (done_acc | sh_done) is all ones in the current cycle: to SCAN if pending!=0, otherwise to DONE.
REQ-023 wait counter shall clear on ISSUE and increment each WAIT cycle; reaching TIMEOUT without completion sets timeout_err and exits exactly as in REQ-022.
REQ-024 DONE: frame_done=1 for this cycle only; next IDLE.
REQ-025 Layer order shall be strictly ascending index, one layer per ISSUE, each enabled layer exactly once per frame.
REQ-026 Latency: accepted strobe at cycle N gives first sh_strobe at N+2; all-disabled frame gives frame_done at N+1.
REQ-027 abort in SCAN, ISSUE, WAIT or DONE: next state IDLE, pending cleared, no frame_done, no further sh_strobe; abort in IDLE ignored.
REQ-028 abort and completion in the same cycle: abort wins.
REQ-029 layer_sel shall hold its value outside SCAN; layer_valid gates its meaning.
REQ-030 sh_done bits seen outside ISSUE/WAIT shall be discarded.

Reset
REQ-031 aresetn low shall immediately force IDLE, pending=0, done_acc=0, wait counter=0.
REQ-032 Reset values: ready=1, sh_strobe=0, layer_sel=0, layer_valid=0, frame_done=0, timeout_err=0.
REQ-033 Reset mid-frame shall drop all in-progress work; first strobe after release starts a fresh frame.

Verification (ZGROUPS=1, SHADERS_POW2=3, TIMEOUT=8)
REQ-034 layer_en=5'b10101, strobe at cycle 0, all sh_done=8'hFF two cycles after each sh_strobe -> layer_sel 0,2,4 in order, three sh_strobe pulses, frame_done one cycle, ready=1 after.
REQ-035 layer_en=5'b00000, strobe at cycle 0 -> frame_done at cycle 1, no sh_strobe, ready=1 at cycle 2.
REQ-036 layer_en=5'b00010, sh_done lanes split 8'h0F then 8'hF0 in separate cycles -> WAIT exits only after the 8'hF0 cycle, frame_done follows.
REQ-037 layer_en=5'b00001, sh_done never asserted -> timeout_err=1 after 8 WAIT cycles, frame_done pulses, timeout_err clears on the next accepted strobe.
REQ-038 layer_en=5'b11111, abort asserted in WAIT of layer 1 -> IDLE next cycle, no frame_done, no sh_strobe for layers 2..4.
REQ-039 aresetn pulsed low during WAIT, plus strobe held high while busy -> all outputs at reset values, busy strobes never start a second frame.

Source files
------------

// File: rtl/shader_zsched.sv
// Z-layer scheduler: walks the enabled layers in ascending order, broadcasts a start
// pulse to the shader bank per layer and waits for every lane to finish or time out.
`timescale 1ns/1ps
module shader_zsched #(
    parameter  int unsigned ZGROUPS      = 1,
    parameter  int unsigned SHADERS_POW2 = 3,
    parameter  int unsigned TIMEOUT      = 255,
    localparam int unsigned ZLAYERS      = 5 * ZGROUPS,
    localparam int unsigned SHADERS      = 2 ** SHADERS_POW2,
    localparam int unsigned LSEL_W       = $clog2(ZLAYERS)
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               strobe,
    input  logic [ZLAYERS-1:0] layer_en,
    input  logic               abort,
    input  logic [SHADERS-1:0] sh_done,
    output logic               ready,
    output logic [SHADERS-1:0] sh_strobe,
    output logic [LSEL_W-1:0]  layer_sel,
    output logic               layer_valid,
    output logic               frame_done,
    output logic               timeout_err
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [ZLAYERS-1:0] pending_q, pending_d;
    logic [SHADERS-1:0] done_acc_q, done_acc_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [LSEL_W-1:0]  layer_sel_q, layer_sel_d;
    logic               timeout_err_q, timeout_err_d;
    logic               ready_q, ready_d;
    logic [SHADERS-1:0] sh_strobe_q, sh_strobe_d;
    logic               layer_valid_q, layer_valid_d;
    logic               frame_done_q, frame_done_d;

    logic               done_all;
    logic               timed_out;
    logic [LSEL_W-1:0]  lowest_idx;

    assign done_all  = &(done_acc_q | sh_done);
    assign timed_out = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    // Priority pick of the lowest pending layer
    always_comb begin
        lowest_idx = '0;
        for (int i = int'(ZLAYERS) - 1; i >= 0; i--) begin
            if (pending_q[i]) lowest_idx = LSEL_W'(i);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (strobe) state_d = (layer_en != '0) ? S_SCAN : S_DONE;
            S_SCAN:  state_d = abort ? S_IDLE : S_ISSUE;
            S_ISSUE: state_d = abort ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (abort)                       state_d = S_IDLE;
                else if (done_all || timed_out)  state_d = (pending_q != '0) ? S_SCAN : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates plus outputs registered off the next state
    always_comb begin
        pending_d     = pending_q;
        done_acc_d    = done_acc_q;
        wait_cnt_d    = wait_cnt_q;
        layer_sel_d   = layer_sel_q;
        timeout_err_d = timeout_err_q;
        ready_d       = (state_d == S_IDLE);
        sh_strobe_d   = {SHADERS{state_d == S_ISSUE}};
        layer_valid_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
        frame_done_d  = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    pending_d     = layer_en;
                    timeout_err_d = 1'b0;
                end
            end
            S_SCAN: begin
                layer_sel_d = lowest_idx;
                pending_d   = pending_q & (pending_q - ZLAYERS'(1));
                done_acc_d  = '0;
            end
            S_ISSUE: begin
                done_acc_d = done_acc_q | sh_done;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                done_acc_d = done_acc_q | sh_done;
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                if (timed_out && !done_all && !abort) timeout_err_d = 1'b1;
            end
            default: ;
        endcase
        if (abort && state_q != S_IDLE) pending_d = '0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pending_q     <= '0;
            done_acc_q    <= '0;
            wait_cnt_q    <= '0;
            layer_sel_q   <= '0;
            timeout_err_q <= 1'b0;
            ready_q       <= 1'b1;
            sh_strobe_q   <= '0;
            layer_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            done_acc_q    <= done_acc_d;
            wait_cnt_q    <= wait_cnt_d;
            layer_sel_q   <= layer_sel_d;
            timeout_err_q <= timeout_err_d;
            ready_q       <= ready_d;
            sh_strobe_q   <= sh_strobe_d;
            layer_valid_q <= layer_valid_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign ready       = ready_q;
    assign sh_strobe   = sh_strobe_q;
    assign layer_sel   = layer_sel_q;
    assign layer_valid = layer_valid_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;

endmodule
